// File: rtl/cia_pkg.sv
// Shared CIA types: byte register type and the serial-port partner TX state.
package cia;

  typedef logic [7:0] reg8_t;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_LOW,
    SP_HIGH,
    SP_GAP
  } sp_partner_state_t;

endpackage

// File: rtl/cia_sync2.sv
// Two-flop synchronizer for an asynchronous pad input; resets to RST_VAL.
module cia_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic res_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cia_sp_partner.sv
// Link partner for the CIA serial port: clocks bytes out on CNT/SP when the CIA
// is in input mode, and samples SP on CNT rising edges when the CIA drives it.
module cia_sp_partner
  import cia::*;
#(
  parameter int unsigned CNT_HALF   = 4,
  parameter int unsigned GAP_CYC    = 8,
  parameter int unsigned RX_TIMEOUT = 1024
) (
  input  logic  clk,
  input  logic  res_n,
  input  logic  tx_valid,
  input  reg8_t tx_data,
  output logic  tx_ready,
  input  logic  cnt_i,
  input  logic  sp_i,
  output logic  cnt_o,
  output logic  cnt_oe,
  output logic  sp_o,
  output logic  sp_oe,
  output reg8_t rx_data,
  output logic  rx_valid,
  input  logic  rx_ack,
  output logic  rx_overrun
);

  localparam int unsigned TMAX = (CNT_HALF > GAP_CYC) ? CNT_HALF : GAP_CYC;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam int unsigned TOW  = $clog2(RX_TIMEOUT + 1);
  localparam logic [TW-1:0]  HALF_LAST = TW'(CNT_HALF - 1);
  localparam logic [TW-1:0]  GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(RX_TIMEOUT - 1);

  sp_partner_state_t state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        bit_q, bit_d;
  reg8_t             tx_sr_q, tx_sr_d;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= SP_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      tx_sr_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      tx_sr_q <= tx_sr_d;
    end
  end

  // Outputs are decoded from the state register so reset releases the pads at once.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    tx_sr_d  = tx_sr_q;
    tx_ready = 1'b0;
    cnt_o    = 1'b1;
    sp_o     = 1'b1;
    cnt_oe   = 1'b1;
    sp_oe    = 1'b1;
    unique case (state_q)
      SP_IDLE: begin
        tx_ready = 1'b1;
        cnt_oe   = 1'b0;
        sp_oe    = 1'b0;
        if (tx_valid) begin
          tx_sr_d = tx_data;
          bit_d   = '0;
          timer_d = '0;
          state_d = SP_LOW;
        end
      end
      SP_LOW: begin
        cnt_o = 1'b0;
        sp_o  = tx_sr_q[7];
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = SP_HIGH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SP_HIGH: begin
        sp_o = tx_sr_q[7];
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = SP_GAP;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            state_d = SP_LOW;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SP_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = SP_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = SP_IDLE;
    endcase
  end

  logic cnt_s, sp_s;

  cia_sync2 #(.RST_VAL(1'b1)) u_sync_cnt (
    .clk   (clk),
    .res_n (res_n),
    .d     (cnt_i),
    .q     (cnt_s)
  );

  cia_sync2 #(.RST_VAL(1'b1)) u_sync_sp (
    .clk   (clk),
    .res_n (res_n),
    .d     (sp_i),
    .q     (sp_s)
  );

  logic           cnt_prev_q;
  logic [6:0]     rx_sr_q;
  logic [2:0]     rx_cnt_q;
  logic [TOW-1:0] rx_to_q;
  logic           rx_en, cnt_rise, byte_done;

  assign rx_en     = (state_q == SP_IDLE);
  assign cnt_rise  = cnt_s & ~cnt_prev_q;
  assign byte_done = rx_en & cnt_rise & (rx_cnt_q == 3'd7);

  // Edge detector keeps tracking during TX so no stale edge appears on return to IDLE.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_prev_q <= 1'b1;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
      rx_to_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      cnt_prev_q <= cnt_s;
      if (!rx_en) begin
        rx_cnt_q <= '0;
        rx_to_q  <= '0;
      end else if (cnt_rise) begin
        rx_to_q  <= '0;
        rx_sr_q  <= {rx_sr_q[5:0], sp_s};
        rx_cnt_q <= rx_cnt_q + 3'd1;
      end else if (rx_cnt_q != '0) begin
        if (rx_to_q == TO_LAST) begin
          rx_cnt_q <= '0;
          rx_to_q  <= '0;
        end else begin
          rx_to_q <= rx_to_q + TOW'(1);
        end
      end

      if (byte_done) begin
        rx_data    <= {rx_sr_q, sp_s};
        rx_valid   <= 1'b1;
        rx_overrun <= ~rx_ack & (rx_overrun | rx_valid);
      end else if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cia_sp_partner.sv
// Self-checking bench for cia_sp_partner: TX via a CIA-style pad sampler, RX via driven pads.
module tb_cia_sp_partner;

  localparam int CH = 4;
  localparam int GC = 8;
  localparam int RT = 1024;

  logic       clk = 1'b0;
  logic       res_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_ack = 1'b0;
  logic       cnt_drv = 1'b1;
  logic       sp_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_ready, cnt_o, cnt_oe, sp_o, sp_oe, rx_valid, rx_overrun;
  logic [7:0] rx_data;
  logic       cnt_i, sp_i;

  assign cnt_i = loop_en ? (cnt_oe ? cnt_o : 1'b1) : cnt_drv;
  assign sp_i  = loop_en ? (sp_oe ? sp_o : 1'b1) : sp_drv;

  cia_sp_partner #(.CNT_HALF(CH), .GAP_CYC(GC), .RX_TIMEOUT(RT)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .cnt_i      (cnt_i),
    .sp_i       (sp_i),
    .cnt_o      (cnt_o),
    .cnt_oe     (cnt_oe),
    .sp_o       (sp_o),
    .sp_oe      (sp_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // CIA-style receiver on the partner's pads: sample SP on CNT rising edges.
  logic        p_cnt = 1'b1, p_oe = 1'b0, p_sp = 1'b1, rise_sp = 1'b1;
  logic [7:0]  samp = 8'h00;
  int          nbits = 0, nfall = 0;
  int unsigned last_fall = 0;
  logic        saw_rx = 1'b0;

  always @(negedge clk) begin
    if (cnt_oe && !p_oe) begin
      nbits = 0;
      nfall = 0;
      samp  = 8'h00;
    end
    if (cnt_oe && p_oe && cnt_o && !p_cnt) begin
      samp    = {samp[6:0], sp_o};
      nbits++;
      rise_sp = sp_o;
    end
    if (cnt_oe && !cnt_o && p_cnt) begin
      if (nfall > 0) begin
        chk("cnt_fall_spacing", cyc - last_fall, 2 * CH);
        chk("sp_held_high", p_sp, rise_sp);
      end
      last_fall = cyc;
      nfall++;
    end
    if (loop_en && rx_valid) saw_rx = 1'b1;
    p_cnt = cnt_o;
    p_oe  = cnt_oe;
    p_sp  = sp_o;
  end

  task automatic send_tx(input logic [7:0] b, input bit poke_busy, output int lat);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!tx_ready && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("tx_ready_drop", tx_ready, 1'b0);
    lat = 0;
    while (!tx_ready && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (poke_busy && lat == 10) begin
        tx_valid = 1'b1;
        tx_data  = ~b;
      end else begin
        tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      cnt_drv = 1'b0;
      sp_drv  = b[7-i];
      repeat (half) @(posedge clk);
      #1 cnt_drv = 1'b1;
      repeat (half) @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
  endtask

  typedef struct {
    logic       ack;
    logic [7:0] b;
    int         half;
    logic [7:0] ed;
    logic       ev;
    logic       eo;
  } rx_vec_t;

  rx_vec_t vec[6];

  initial begin
    int         lat;
    logic [7:0] b, md;
    logic       mv, mo;
    int         half;

    vec[0] = '{1'b1, 8'h11, 4, 8'h11, 1'b1, 1'b0};
    vec[1] = '{1'b0, 8'h22, 3, 8'h22, 1'b1, 1'b1};
    vec[2] = '{1'b0, 8'h5A, 5, 8'h5A, 1'b1, 1'b1};
    vec[3] = '{1'b1, 8'h00, 2, 8'h00, 1'b1, 1'b0};
    vec[4] = '{1'b1, 8'hFF, 6, 8'hFF, 1'b1, 1'b0};
    vec[5] = '{1'b0, 8'h96, 4, 8'h96, 1'b1, 1'b1};

    #3 res_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_cnt_o", cnt_o, 1'b1);
    chk("rst_cnt_oe", cnt_oe, 1'b0);
    chk("rst_sp_o", sp_o, 1'b1);
    chk("rst_sp_oe", sp_oe, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_overrun", rx_overrun, 1'b0);
    @(negedge clk) res_n = 1'b1;
    repeat (3) @(posedge clk);

    // TX 0xA5 with an ignored tx_valid poke while busy
    send_tx(8'hA5, 1'b1, lat);
    chk("tx_latency", lat, 16 * CH + GC);
    chk("tx_sampled", samp, 8'hA5);
    chk("tx_nbits", nbits, 8);
    chk("tx_nfall", nfall, 8);
    chk("tx_idle_cnt_oe", cnt_oe, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("tx_no_queue", tx_ready, 1'b1);

    for (int t = 0; t < 4; t++) begin
      b = 8'($urandom);
      send_tx(b, 1'b0, lat);
      chk("tx_rand_latency", lat, 16 * CH + GC);
      chk("tx_rand_sampled", samp, b);
    end

    // Async reset in the middle of a LOW phase
    @(posedge clk); #1;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("pre_rst_cnt_low", cnt_o, 1'b0);
    res_n = 1'b0;
    #1;
    chk("midrst_cnt_oe", cnt_oe, 1'b0);
    chk("midrst_sp_oe", sp_oe, 1'b0);
    chk("midrst_tx_ready", tx_ready, 1'b1);
    chk("midrst_cnt_o", cnt_o, 1'b1);
    @(negedge clk) res_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // RX 0x3C with latency window on the final edge
    send_bits(8'h3C, 7, 4);
    cnt_drv = 1'b0;
    sp_drv  = 1'b0;
    repeat (4) @(posedge clk);
    #1 cnt_drv = 1'b1;
    @(posedge clk); #1 chk("rx_not_early", rx_valid, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rx_3c_valid", rx_valid, 1'b1);
    chk("rx_3c_data", rx_data, 8'h3C);
    chk("rx_3c_overrun", rx_overrun, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (vec[i].ack) ack_pulse();
      send_bits(vec[i].b, 8, vec[i].half);
      repeat (4) @(posedge clk);
      #1;
      chk("vec_rx_data", rx_data, vec[i].ed);
      chk("vec_rx_valid", rx_valid, vec[i].ev);
      chk("vec_rx_overrun", rx_overrun, vec[i].eo);
    end
    ack_pulse();
    #1;
    chk("ack_clears_valid", rx_valid, 1'b0);
    chk("ack_clears_overrun", rx_overrun, 1'b0);
    chk("ack_keeps_data", rx_data, 8'h96);

    // rx_ack on the completion edge: new byte wins
    send_bits(8'h44, 8, 3);
    send_bits(8'h55, 8, 3);
    repeat (3) @(posedge clk);
    #1 chk("pre_coinc_overrun", rx_overrun, 1'b1);
    send_bits(8'hC3, 7, 3);
    cnt_drv = 1'b0;
    sp_drv  = 1'b1;
    repeat (3) @(posedge clk);
    #1 cnt_drv = 1'b1;
    @(posedge clk); @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
    chk("coinc_valid", rx_valid, 1'b1);
    chk("coinc_overrun", rx_overrun, 1'b0);
    chk("coinc_data", rx_data, 8'hC3);

    // Partial byte discarded after the timeout
    ack_pulse();
    send_bits(8'hFF, 3, 4);
    repeat (RT + 4) @(posedge clk);
    #1;
    send_bits(8'h81, 8, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_data", rx_data, 8'h81);
    chk("timeout_valid", rx_valid, 1'b1);
    chk("timeout_overrun", rx_overrun, 1'b0);

    // Randomized RX against a rule-level model
    ack_pulse();
    mv = 1'b0;
    mo = 1'b0;
    md = rx_data;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        mv = 1'b0;
        mo = 1'b0;
      end
      b    = 8'($urandom);
      half = $urandom_range(2, 6);
      send_bits(b, 8, half);
      repeat (4) @(posedge clk);
      #1;
      mo = mo | mv;
      mv = 1'b1;
      md = b;
      chk("rand_rx_data", rx_data, md);
      chk("rand_rx_valid", rx_valid, mv);
      chk("rand_rx_overrun", rx_overrun, mo);
    end

    // Own TX looped back must not be received
    ack_pulse();
    loop_en = 1'b1;
    saw_rx  = 1'b0;
    send_tx(8'hFF, 1'b0, lat);
    repeat (6) @(posedge clk);
    #1;
    chk("self_excl_seen", saw_rx, 1'b0);
    chk("self_excl_valid", rx_valid, 1'b0);
    chk("self_excl_sampled", samp, 8'hFF);
    loop_en = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
